// File: rtl/decode_cycle.sv
// RV32I decode stage: control/immediate decode, 32x32 register file with
// write-through bypass, and the D/E pipeline register feeding execute.
module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] Instr_D,
    input  logic [XLEN-1:0] PC_D,
    input  logic [XLEN-1:0] PCPlusD,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteE,
    output logic            ALUSrcE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [4:0]      RS1_E,
    output logic [4:0]      RS2_E,
    output logic [4:0]      RD_E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlusE,
    output logic            IllegalE
);

    typedef enum logic [6:0] {
        OP_LW  = 7'b0000011,
        OP_SW  = 7'b0100011,
        OP_R   = 7'b0110011,
        OP_I   = 7'b0010011,
        OP_BEQ = 7'b1100011,
        OP_JAL = 7'b1101111
    } opcode_t;

    opcode_t         opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

    assign opcode = opcode_t'(Instr_D[6:0]);
    assign funct3 = Instr_D[14:12];
    assign rs1    = Instr_D[19:15];
    assign rs2    = Instr_D[24:20];
    assign rd     = Instr_D[11:7];

    assign imm_i = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:20]};
    assign imm_s = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
    assign imm_b = {{(XLEN-13){Instr_D[31]}}, Instr_D[31], Instr_D[7],
                    Instr_D[30:25], Instr_D[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){Instr_D[31]}}, Instr_D[31], Instr_D[19:12],
                    Instr_D[20], Instr_D[30:21], 1'b0};

    logic [2:0] funct_alu;
    logic       funct_bad;

    always_comb begin
        funct_alu = 3'b000;
        funct_bad = 1'b0;
        case (funct3)
            3'b000:  funct_alu = (opcode == OP_R && Instr_D[30]) ? 3'b001 : 3'b000;
            3'b010:  funct_alu = 3'b101;
            3'b110:  funct_alu = 3'b011;
            3'b111:  funct_alu = 3'b010;
            default: funct_bad = 1'b1;
        endcase
    end

    logic            reg_write, alu_src, mem_write, branch, jump, illegal;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctl;
    logic [XLEN-1:0] imm;

    always_comb begin
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        result_src = 2'b00;
        alu_ctl    = 3'b000;
        imm        = '0;
        illegal    = 1'b0;
        case (opcode)
            OP_LW:  begin reg_write = 1'b1; alu_src = 1'b1; result_src = 2'b01; imm = imm_i; end
            OP_SW:  begin mem_write = 1'b1; alu_src = 1'b1; imm = imm_s; end
            OP_R:   begin reg_write = 1'b1; alu_ctl = funct_alu; illegal = funct_bad; end
            OP_I:   begin reg_write = 1'b1; alu_src = 1'b1; alu_ctl = funct_alu;
                          imm = imm_i; illegal = funct_bad; end
            OP_BEQ: begin branch = 1'b1; alu_ctl = 3'b001; imm = imm_b; end
            OP_JAL: begin reg_write = 1'b1; jump = 1'b1; result_src = 2'b10; imm = imm_j; end
            // An all-zero word is the fetch reset bubble, not an illegal opcode.
            default: illegal = (Instr_D != '0);
        endcase
        if (illegal) begin
            reg_write  = 1'b0;
            alu_src    = 1'b0;
            mem_write  = 1'b0;
            branch     = 1'b0;
            jump       = 1'b0;
            result_src = 2'b00;
            alu_ctl    = 3'b000;
        end
    end

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rd1, rd2;
    logic            wb_active;

    assign wb_active = RegWriteW && (RDW != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_active) begin
            regs[RDW] <= ResultW;
        end
    end

    assign rd1 = (rs1 == '0) ? '0 : (wb_active && RDW == rs1) ? ResultW : regs[rs1];
    assign rd2 = (rs2 == '0) ? '0 : (wb_active && RDW == rs2) ? ResultW : regs[rs2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || FlushE) begin
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RD1_E       <= '0;
            RD2_E       <= '0;
            Imm_Ext_E   <= '0;
            RS1_E       <= '0;
            RS2_E       <= '0;
            RD_E        <= '0;
            PCE         <= '0;
            PCPlusE     <= '0;
            IllegalE    <= 1'b0;
        end else begin
            RegWriteE   <= reg_write;
            ALUSrcE     <= alu_src;
            MemWriteE   <= mem_write;
            BranchE     <= branch;
            JumpE       <= jump;
            ResultSrcE  <= result_src;
            ALUControlE <= alu_ctl;
            RD1_E       <= rd1;
            RD2_E       <= rd2;
            Imm_Ext_E   <= imm;
            RS1_E       <= rs1;
            RS2_E       <= rs2;
            RD_E        <= rd;
            PCE         <= PC_D;
            PCPlusE     <= PCPlusD;
            IllegalE    <= illegal;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios plus randomized
// instruction streams compared against a behavioural decode/regfile model.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] Instr_D = '0, PC_D = '0, PCPlusD = '0, ResultW = '0;
    logic        FlushE = 1'b0, RegWriteW = 1'b0;
    logic [4:0]  RDW = '0;
    logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlusE;
    logic [4:0]  RS1_E, RS2_E, RD_E;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_cycle #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .Instr_D(Instr_D), .PC_D(PC_D), .PCPlusD(PCPlusD),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlusE(PCPlusE), .IllegalE(IllegalE)
    );

    typedef struct packed {
        logic        reg_write, alu_src, mem_write, branch, jump;
        logic [1:0]  result_src;
        logic [2:0]  alu_ctl;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, pc_plus;
        logic        illegal;
    } de_t;

    logic [31:0] mregs [32];

    function automatic de_t sample();
        return '{RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUControlE,
                 RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlusE, IllegalE};
    endfunction

    function automatic logic [31:0] read_model(input int r, input logic we,
                                               input int rdw, input logic [31:0] resw);
        if (r == 0) return 0;
        if (we && rdw == r) return resw;
        return mregs[r];
    endfunction

    // Reference decode from the instruction-set rules, immediates by signed arithmetic.
    function automatic de_t predict(input logic [31:0] instr, input logic [31:0] pc,
                                    input logic flush, input logic we,
                                    input logic [4:0] rdw, input logic [31:0] resw);
        de_t e;
        int  s, op, f3, alu_f;
        bit  funct_ok;
        e = '0;
        if (flush) return e;
        s  = int'(instr);
        op = int'(instr & 32'h7F);
        f3 = int'((instr >> 12) & 7);
        e.rs1 = 5'((instr >> 15) & 31);
        e.rs2 = 5'((instr >> 20) & 31);
        e.rd  = 5'((instr >> 7) & 31);
        e.pc = pc;
        e.pc_plus = pc + 1;
        e.rd1 = read_model(int'(e.rs1), we, int'(rdw), resw);
        e.rd2 = read_model(int'(e.rs2), we, int'(rdw), resw);
        funct_ok = (f3 == 0 || f3 == 2 || f3 == 6 || f3 == 7);
        case (f3)
            0:       alu_f = (op == 'h33 && instr[30]) ? 1 : 0;
            2:       alu_f = 5;
            6:       alu_f = 3;
            default: alu_f = 2;
        endcase
        case (op)
            'h03: begin e.reg_write = 1; e.alu_src = 1; e.result_src = 1; e.imm = s >>> 20; end
            'h23: begin e.mem_write = 1; e.alu_src = 1;
                        e.imm = ((s >>> 25) << 5) | ((s >> 7) & 31); end
            'h33: begin e.reg_write = 1; e.alu_ctl = 3'(alu_f); e.illegal = !funct_ok; end
            'h13: begin e.reg_write = 1; e.alu_src = 1; e.alu_ctl = 3'(alu_f);
                        e.imm = s >>> 20; e.illegal = !funct_ok; end
            'h63: begin e.branch = 1; e.alu_ctl = 1;
                        e.imm = ((s >>> 31) << 12) | (((s >> 7) & 1) << 11)
                              | (((s >> 25) & 63) << 5) | (((s >> 8) & 15) << 1); end
            'h6F: begin e.reg_write = 1; e.jump = 1; e.result_src = 2;
                        e.imm = ((s >>> 31) << 20) | (((s >> 12) & 255) << 12)
                              | (((s >> 20) & 1) << 11) | (((s >> 21) & 1023) << 1); end
            default: e.illegal = (instr != 0);
        endcase
        if (e.illegal) begin
            {e.reg_write, e.alu_src, e.mem_write, e.branch, e.jump} = '0;
            e.result_src = 0;
            e.alu_ctl = 0;
        end
        return e;
    endfunction

    // Drive one decode cycle, advance past the posedge, update the model regfile.
    task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                        input logic we, input logic [4:0] rdw, input logic [31:0] resw,
                        output de_t exp);
        Instr_D = instr; PC_D = pc; PCPlusD = pc + 1; FlushE = flush;
        RegWriteW = we; RDW = rdw; ResultW = resw;
        exp = predict(instr, pc, flush, we, rdw, resw);
        @(posedge clk);
        if (we && rdw != 0) mregs[rdw] = resw;
        #1;
    endtask

    task automatic test_reset();
        de_t exp, got;
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        Instr_D = 32'h00500093; PC_D = 32'h10; PCPlusD = 32'h11;
        repeat (2) @(posedge clk);
        #1;
        got = sample();
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_hold got=%h exp=0", got); end
        rst = 1'b1;
        step(32'h00500093, 32'h10, 0, 0, 0, 0, exp);
        got = sample();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL addi_after_reset got=%h exp=%h", got, exp); end
        checks++;
        if ({RegWriteE, ALUSrcE, Imm_Ext_E, RD_E, ALUControlE} !== {1'b1, 1'b1, 32'd5, 5'd1, 3'b000}) begin
            errors++;
            $display("FAIL addi_fields got=%b %b %h %0d %b exp=1 1 00000005 1 000",
                     RegWriteE, ALUSrcE, Imm_Ext_E, RD_E, ALUControlE);
        end
    endtask

    task automatic test_bypass();
        de_t exp, got;
        step(32'h003100B3, 32'h11, 0, 1, 3, 32'hDEADBEEF, exp);
        got = sample();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL bypass got=%h exp=%h", got, exp); end
        checks++;
        if ({RD2_E, RD1_E, ALUSrcE} !== {32'hDEADBEEF, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL bypass_rd got=%h %h %b exp=deadbeef 00000000 0", RD2_E, RD1_E, ALUSrcE);
        end
    endtask

    task automatic test_sub_beq();
        de_t exp, got;
        step(32'h40208033, 32'h12, 0, 0, 0, 0, exp);
        got = sample();
        checks++;
        if (got !== exp || ALUControlE !== 3'b001) begin
            errors++; $display("FAIL sub got=%h exp=%h", got, exp);
        end
        step(32'hFE000EE3, 32'h13, 0, 0, 0, 0, exp);
        got = sample();
        checks++;
        if (got !== exp || {BranchE, Imm_Ext_E, ALUControlE} !== {1'b1, 32'hFFFFFFFC, 3'b001}) begin
            errors++; $display("FAIL beq got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_sw_jal();
        de_t exp, got;
        step(32'h0020A423, 32'h14, 0, 0, 0, 0, exp);
        got = sample();
        checks++;
        if (got !== exp || {MemWriteE, RegWriteE, Imm_Ext_E} !== {1'b1, 1'b0, 32'd8}) begin
            errors++; $display("FAIL sw got=%h exp=%h", got, exp);
        end
        step(32'h008000EF, 32'h15, 0, 0, 0, 0, exp);
        got = sample();
        checks++;
        if (got !== exp || {JumpE, ResultSrcE, Imm_Ext_E} !== {1'b1, 2'b10, 32'd8}) begin
            errors++; $display("FAIL jal got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_x0_illegal();
        de_t exp, got;
        // x0 write in the same cycle as an x0 read must neither bypass nor stick.
        step(32'h000000B3, 32'h16, 0, 1, 0, 32'h55, exp);
        got = sample();
        checks++;
        if (got !== exp || RD1_E !== 0) begin errors++; $display("FAIL x0_same_cycle got=%h exp=%h", got, exp); end
        step(32'h000000B3, 32'h17, 0, 0, 0, 0, exp);
        got = sample();
        checks++;
        if (got !== exp || RD1_E !== 0) begin errors++; $display("FAIL x0_read got=%h exp=%h", got, exp); end
        step(32'hFFFFFFFF, 32'h18, 0, 0, 0, 0, exp);
        got = sample();
        checks++;
        if (got !== exp || IllegalE !== 1'b1 || {RegWriteE, MemWriteE, BranchE, JumpE} !== 4'b0) begin
            errors++; $display("FAIL illegal got=%h exp=%h", got, exp);
        end
        step(32'h00000000, 32'h19, 0, 0, 0, 0, exp);
        got = sample();
        checks++;
        if (got !== exp || IllegalE !== 1'b0) begin errors++; $display("FAIL nop_bubble got=%h exp=%h", got, exp); end
    endtask

    task automatic test_flush();
        de_t exp, got;
        step(32'h00500093, 32'h20, 1, 1, 7, 32'hCAFE0007, exp);
        got = sample();
        checks++;
        if (got !== '0) begin errors++; $display("FAIL flush got=%h exp=0", got); end
        step(32'h00038133, 32'h21, 0, 0, 0, 0, exp);   // add x2,x7,x0
        got = sample();
        checks++;
        if (got !== exp || RD1_E !== 32'hCAFE0007) begin
            errors++; $display("FAIL write_during_flush got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        de_t exp, got;
        step(32'h00000013, 32'h30, 0, 1, 5, 32'h00001234, exp);
        step(32'h00028013, 32'h31, 0, 0, 0, 0, exp);   // addi x0,x5,0
        got = sample();
        checks++;
        if (got !== exp || RD1_E !== 32'h1234) begin errors++; $display("FAIL pre_reset_read got=%h exp=%h", got, exp); end
        #3 rst = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== '0) begin errors++; $display("FAIL async_reset got=%h exp=0", got); end
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        step(32'h00028013, 32'h32, 0, 0, 0, 0, exp);
        got = sample();
        checks++;
        if (got !== exp || RD1_E !== 0) begin errors++; $display("FAIL post_reset_read got=%h exp=%h", got, exp); end
    endtask

    task automatic test_random();
        de_t exp, got;
        logic [31:0] instr;
        int opcodes[6] = '{'h03, 'h23, 'h33, 'h13, 'h63, 'h6F};
        for (int n = 0; n < 400; n++) begin
            int k = int'($urandom_range(0, 8));
            if (k < 6) instr = ($urandom & 32'hFFFFFF80) | 32'(opcodes[k]);
            else if (k == 6) instr = $urandom;
            else instr = 0;
            step(instr, $urandom, ($urandom_range(0, 7) == 0), 1'($urandom),
                 5'($urandom), $urandom, exp);
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random[%0d] instr=%h got=%h exp=%h", n, instr, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_sub_beq();
        test_sw_jal();
        test_x0_illegal();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Decode stage of the five-stage RV32I pipeline. Consumes the fetch-stage outputs (instruction, PC, PC+1) and decodes control signals and the sign-extended immediate. Reads the 32x32 register file and accepts its write port from writeback. Registers everything into the D/E pipeline register feeding execute. Latency from decode input to execute-stage output is one clock.

Parameters:
XLEN, 32, datapath width; only 32 supported.
NREGS, 32, register-file depth; x0 hardwired to zero.

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-low reset
Instr_D  input  32  instruction from fetch
PC_D  input  32  PC of Instr_D (word address)
PCPlusD  input  32  PC_D+1 from fetch
FlushE  input  1  load bubble into D/E register
RegWriteW  input  1  writeback write enable
RDW  input  5  writeback destination
ResultW  input  32  writeback data
RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE  output  1 each  registered control
ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+1
ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RD1_E, RD2_E  output  32  register operands
Imm_Ext_E  output  32  sign-extended immediate
RS1_E, RS2_E, RD_E  output  5  Instr[19:15], [24:20], [11:7]
PCE, PCPlusE  output  32  registered PC_D / PCPlusD
IllegalE  output  1  unsupported encoding flag

Behaviour:
- Reset (rst=0, asynchronous): all D/E registers and all 32 register-file entries clear to 0. While rst=0, every output is forced to 0.
- Decode, all combinational from Instr_D:
  - lw 0000011: RegWrite=1, ALUSrc=1, ResultSrc=01, ALU add, I-imm.
  - sw 0100011: MemWrite=1, ALUSrc=1, ALU add, S-imm.
  - R 0110011: RegWrite=1, ALUSrc=0, funct-decoded ALU.
  - I-ALU 0010011: RegWrite=1, ALUSrc=1, funct-decoded ALU, I-imm.
  - beq 1100011: Branch=1, ALU sub, B-imm.
  - jal 1101111: RegWrite=1, Jump=1, ResultSrc=10, J-imm.
- Funct-decoded ALU, by funct3:
  - 000: sub only if R-type and funct7[5]=1, else add.
  - 010: slt. 110: or. 111: and.
  - Any other funct3 is illegal.
- Immediates:
  - I = sext(Instr[31:20]).
  - S = sext({Instr[31:25],Instr[11:7]}).
  - B = sext({Instr[31],Instr[7],Instr[30:25],Instr[11:8],1'b0}).
  - J = sext({Instr[31],Instr[19:12],Instr[20],Instr[30:21],1'b0}).
  - Types without an immediate produce 0.
- Instr_D==0 is the fetch reset bubble and is treated as NOP: all controls 0, IllegalE=0.
- Illegal instruction (unknown opcode or funct): all controls 0 (write-free bubble), IllegalE=1. Operand, PC and register-index fields are still captured.
- Register file:
  - Write on posedge clk when RegWriteW=1 and RDW!=0. Writes to x0 are discarded, and reads of x0 return 0.
  - Reads are combinational with write-through bypass: if RegWriteW && RDW!=0 && RDW==RS, read data = ResultW in the same cycle.
- D/E register: on posedge, captures decoded controls, operands, immediate, indices, PC_D and PCPlusD.
- FlushE=1 at posedge:
  - All control outputs and IllegalE load 0.
  - Data/index/PC fields load 0.
  - The register-file write in that same cycle still occurs.
- Reset asserted mid-operation clears the state immediately (async). First valid E-outputs appear one clock after the first posedge with rst=1.

Test Plan:
1. Hold rst=0, apply Instr_D=0x00500093 -> every output 0. Release reset and clock once -> RegWriteE=1, ALUSrcE=1, Imm_Ext_E=5, RD_E=1, ALUControlE=000.
2. Same cycle RegWriteW=1, RDW=3, ResultW=0xDEADBEEF, Instr_D=0x003100B3 (add x1,x2,x3) -> after posedge RD2_E=0xDEADBEEF (bypass), RD1_E=0, ALUControlE=000, ALUSrcE=0.
3. Instr_D=0x40208033 (sub) -> ALUControlE=001. Instr_D=0xFE000EE3 (beq x0,x0,-4) -> BranchE=1, Imm_Ext_E=0xFFFFFFFC, ALUControlE=001.
4. Instr_D=0x0020A423 (sw x2,8(x1)) -> MemWriteE=1, RegWriteE=0, Imm_Ext_E=8. Instr_D=0x008000EF (jal x1,8) -> JumpE=1, ResultSrcE=10, Imm_Ext_E=8.
5. Write RDW=0, ResultW=0x55 with RegWriteW=1, then decode a read of x0 -> RD1_E=0. Instr_D=0xFFFFFFFF -> IllegalE=1, all controls 0.
6. Valid addi with FlushE=1 -> all outputs 0 next cycle. Drop rst mid-stream -> outputs 0 immediately, register file reads 0 after release.
